// File: rtl/acc_arb_pkg.sv
// Shared types for the accelerator memory arbiter: FSM states, operation codes
// and a counter-sizing helper. Pure declarations, no logic.
// No ports. Imported by acc_mem_arbiter and rr_picker.
package acc_arb_pkg;

  // Arbiter FSM states. IDLE is the only non-busy state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Operation latched at grant time.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Width of a down-counter that must hold values 0..lat-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/acc_mem_arbiter_rr_picker.sv
// Purpose: round-robin picker; first requester at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports:
//   req      in  [N-1:0]    request vector
//   ptr      in  [IDW-1:0]  highest-priority index
//   grant    out [N-1:0]    one-hot grant (all zero when no request)
//   grant_id out [IDW-1:0]  index of the granted requester
//   any_req  out            at least one request present
module rr_picker
  import acc_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any_req
);

  // One extra bit so ptr + k never overflows before the wrap subtraction.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  assign any_req = |req;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(N)) begin
        sum = sum - (IDW + 1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Purpose: share one data-memory port among NUM_ACC accelerators, round-robin, one transaction at a time.
// Latency: request seen in IDLE at T -> strobe at T+1; write done at T+2; read valid at T+2+MEM_READ_LATENCY.
// Backpressure: requests are level signals held until their done/valid pulse; unserved requesters simply wait.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   acc_read_en/addr            per-accelerator read request and packed addresses
//   acc_write_en/addr/data      per-accelerator write request, packed addresses and words
//   acc_read_data               last captured read line, broadcast to all accelerators
//   acc_read_data_valid         one-hot 1-cycle pulse to the served reader
//   acc_write_done              one-hot 1-cycle pulse to the served writer
//   mem_addr/mem_read_en/mem_write_en/mem_write_data   registered memory command
//   mem_read_data               memory return, valid MEM_READ_LATENCY cycles after mem_read_en
//   arb_busy                    high whenever the FSM is not in IDLE
module acc_mem_arbiter
  import acc_arb_pkg::*;
#(
  parameter int NUM_ACC          = 4,
  parameter int ADDR_SIZE        = 16,
  parameter int READ_DATA_SIZE   = 512,
  parameter int WRITE_DATA_SIZE  = 32,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ACC-1:0]                   acc_read_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]         acc_read_addr,
  input  logic [NUM_ACC-1:0]                   acc_write_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]         acc_write_addr,
  input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0]   acc_write_data,
  output logic [READ_DATA_SIZE-1:0]            acc_read_data,
  output logic [NUM_ACC-1:0]                   acc_read_data_valid,
  output logic [NUM_ACC-1:0]                   acc_write_done,
  output logic [ADDR_SIZE-1:0]                 mem_addr,
  output logic                                 mem_read_en,
  output logic                                 mem_write_en,
  output logic [WRITE_DATA_SIZE-1:0]           mem_write_data,
  input  logic [READ_DATA_SIZE-1:0]            mem_read_data,
  output logic                                 arb_busy
);

  localparam int IDW   = $clog2(NUM_ACC);
  localparam int CNT_W = cnt_width(MEM_READ_LATENCY);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_READ_LATENCY - 1);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NUM_ACC - 1);

  arb_state_t           state;
  arb_op_t              op;
  logic [IDW-1:0]       id;
  logic [NUM_ACC-1:0]   gnt_oh;
  logic [IDW-1:0]       rr_ptr;
  logic [CNT_W-1:0]     lat_cnt;

  logic [NUM_ACC-1:0]   req;
  logic [NUM_ACC-1:0]   pick_grant;
  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 pick_is_rd;
  logic [ADDR_SIZE-1:0]       pick_rd_addr;
  logic [ADDR_SIZE-1:0]       pick_wr_addr;
  logic [WRITE_DATA_SIZE-1:0] pick_wr_data;

  // A read and a write on the same accelerator count as one request; the
  // read wins this grant and the write comes back on a later one.
  assign req = acc_read_en | acc_write_en;

  rr_picker #(
    .N   (NUM_ACC),
    .IDW (IDW)
  ) u_picker (
    .req      (req),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any_req  (pick_any)
  );

  assign pick_is_rd   = acc_read_en[pick_id];
  assign pick_rd_addr = acc_read_addr[pick_id*ADDR_SIZE +: ADDR_SIZE];
  assign pick_wr_addr = acc_write_addr[pick_id*ADDR_SIZE +: ADDR_SIZE];
  assign pick_wr_data = acc_write_data[pick_id*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];

  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      op                  <= OP_READ;
      id                  <= '0;
      gnt_oh              <= '0;
      rr_ptr              <= '0;
      lat_cnt             <= '0;
      mem_addr            <= '0;
      mem_write_data      <= '0;
      mem_read_en         <= 1'b0;
      mem_write_en        <= 1'b0;
      acc_read_data       <= '0;
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;
    end else begin
      // Strobes and pulses are single-cycle; each state re-asserts as needed.
      mem_read_en         <= 1'b0;
      mem_write_en        <= 1'b0;
      acc_read_data_valid <= '0;
      acc_write_done      <= '0;

      unique case (state)
        IDLE: begin
          if (pick_any) begin
            // The memory command registers double as the address/data latch,
            // so later changes on the request lines are ignored.
            id     <= pick_id;
            gnt_oh <= pick_grant;
            if (pick_is_rd) begin
              op          <= OP_READ;
              mem_addr    <= pick_rd_addr;
              mem_read_en <= 1'b1;
            end else begin
              op             <= OP_WRITE;
              mem_addr       <= pick_wr_addr;
              mem_write_data <= pick_wr_data;
              mem_write_en   <= 1'b1;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (op == OP_READ) begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT_RD;
          end else begin
            acc_write_done <= gnt_oh;
            state          <= RESP;
          end
        end

        WAIT_RD: begin
          if (lat_cnt == '0) begin
            acc_read_data       <= mem_read_data;
            acc_read_data_valid <= gnt_oh;
            state               <= RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          // The pulse is visible this cycle; the following IDLE cycle lets the
          // served requester drop its line before anything is re-granted.
          rr_ptr <= (id == LAST_ID) ? '0 : id + IDW'(1);
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Purpose: directed self-checking bench for acc_mem_arbiter (latency 1 and latency 3 instances).
// Latency: not applicable.
// Backpressure: not applicable.
module tb_acc_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int RW = 512;
  localparam int WW = 32;
  localparam logic [RW-1:0] GARB = {16{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic [N-1:0]    rd_en = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]    wr_en = '0;
  logic [N*AW-1:0] wr_addr = '0;
  logic [N*WW-1:0] wr_data = '0;
  logic [RW-1:0]   rdata;
  logic [N-1:0]    rvalid;
  logic [N-1:0]    wdone;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [WW-1:0]   mem_wdata;
  logic [RW-1:0]   mem_rdata = GARB;
  logic            busy;

  // Latency-3 instance (reads only)
  logic [N-1:0]    rd_en3 = '0;
  logic [N*AW-1:0] rd_addr3 = '0;
  logic [N-1:0]    wr_en3 = '0;
  logic [N*AW-1:0] wr_addr3 = '0;
  logic [N*WW-1:0] wr_data3 = '0;
  logic [RW-1:0]   rdata3;
  logic [N-1:0]    rvalid3;
  logic [N-1:0]    wdone3;
  logic [AW-1:0]   mem_addr3;
  logic            mem_rd3;
  logic            mem_wr3;
  logic [WW-1:0]   mem_wdata3;
  logic [RW-1:0]   p0 = GARB, p1 = GARB, p2 = GARB;
  logic            busy3;

  int errors = 0;
  int checks = 0;

  function automatic logic [RW-1:0] line_of(input logic [AW-1:0] a);
    line_of = {16{a, ~a}};
  endfunction

  acc_mem_arbiter #(
    .NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
    .WRITE_DATA_SIZE(WW), .MEM_READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .acc_read_en(rd_en), .acc_read_addr(rd_addr),
    .acc_write_en(wr_en), .acc_write_addr(wr_addr), .acc_write_data(wr_data),
    .acc_read_data(rdata), .acc_read_data_valid(rvalid), .acc_write_done(wdone),
    .mem_addr(mem_addr), .mem_read_en(mem_rd), .mem_write_en(mem_wr),
    .mem_write_data(mem_wdata), .mem_read_data(mem_rdata), .arb_busy(busy)
  );

  acc_mem_arbiter #(
    .NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW),
    .WRITE_DATA_SIZE(WW), .MEM_READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst),
    .acc_read_en(rd_en3), .acc_read_addr(rd_addr3),
    .acc_write_en(wr_en3), .acc_write_addr(wr_addr3), .acc_write_data(wr_data3),
    .acc_read_data(rdata3), .acc_read_data_valid(rvalid3), .acc_write_done(wdone3),
    .mem_addr(mem_addr3), .mem_read_en(mem_rd3), .mem_write_en(mem_wr3),
    .mem_write_data(mem_wdata3), .mem_read_data(p2), .arb_busy(busy3)
  );

  // Memory models: data is only meaningful exactly MEM_READ_LATENCY cycles
  // after the strobe; every other cycle returns a garbage pattern.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? line_of(mem_addr) : GARB;
    p0 <= mem_rd3 ? line_of(mem_addr3) : GARB;
    p1 <= p0;
    p2 <= p1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
    checks++; if (rvalid !== 4'b0 || wdone !== 4'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b done=%b want 0000 0000", rvalid, wdone); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_cmd: got addr=%h data=%h want 0 0", mem_addr, mem_wdata); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (busy3 !== 1'b0 || mem_rd3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got busy=%b rd=%b want 0 0", busy3, mem_rd3); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    wr_addr[1*AW +: AW] = 16'h5000;
    wr_data[1*WW +: WW] = 32'h5;
    wr_en[1] = 1'b1;
    tick;  // T+1
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1 0", mem_wr, mem_rd); end
    checks++; if (mem_addr !== 16'h5000 || mem_wdata !== 32'h5) begin errors++; $display("FAIL wr_cmd: got addr=%h data=%h want 5000 00000005", mem_addr, mem_wdata); end
    checks++; if (wdone !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL wr_t1: got done=%b busy=%b want 0000 1", wdone, busy); end
    tick;  // T+2
    checks++; if (wdone !== 4'b0010 || mem_wr !== 1'b0) begin errors++; $display("FAIL wr_done: got done=%b wr=%b want 0010 0", wdone, mem_wr); end
    wr_en[1] = 1'b0;
    tick;  // T+3
    checks++; if (wdone !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL wr_after: got done=%b busy=%b want 0000 0", wdone, busy); end
    tick;
  endtask

  task automatic test_single_read;
    rd_addr[2*AW +: AW] = 16'h1000;
    rd_en[2] = 1'b1;
    tick;  // T+1
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h1000) begin errors++; $display("FAIL rd_strobe: got rd=%b addr=%h want 1 1000", mem_rd, mem_addr); end
    tick;  // T+2
    checks++; if (rvalid !== 4'b0000 || mem_rd !== 1'b0) begin errors++; $display("FAIL rd_t2: got valid=%b rd=%b want 0000 0", rvalid, mem_rd); end
    tick;  // T+3
    checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL rd_valid: got %b want 0100", rvalid); end
    checks++; if (rdata !== line_of(16'h1000)) begin errors++; $display("FAIL rd_data: got %h want %h", rdata, line_of(16'h1000)); end
    rd_en[2] = 1'b0;
    tick;  // T+4
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rd_pulse_len: got %b want 0000", rvalid); end
    tick;
  endtask

  task automatic test_read_lat3;
    rd_addr3[2*AW +: AW] = 16'h2345;
    rd_en3[2] = 1'b1;
    tick;  // T+1
    checks++; if (mem_rd3 !== 1'b1 || mem_addr3 !== 16'h2345) begin errors++; $display("FAIL lat3_strobe: got rd=%b addr=%h want 1 2345", mem_rd3, mem_addr3); end
    tick;  // T+2
    tick;  // T+3
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL lat3_t3: got %b want 0000", rvalid3); end
    tick;  // T+4
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL lat3_t4: got %b want 0000", rvalid3); end
    tick;  // T+5
    checks++; if (rvalid3 !== 4'b0100) begin errors++; $display("FAIL lat3_valid: got %b want 0100", rvalid3); end
    checks++; if (rdata3 !== line_of(16'h2345)) begin errors++; $display("FAIL lat3_data: got %h want %h", rdata3, line_of(16'h2345)); end
    rd_en3[2] = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_round_robin;
    int got [5];
    int n;
    int gid;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = 16'h0100 + 16'(i);
      wr_data[i*WW +: WW] = 32'hA0 + 32'(i);
    end
    wr_en = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick;
      if (wdone !== 4'b0000) begin
        checks++;
        if ($countones(wdone) != 1) begin errors++; $display("FAIL rr_onehot: got %b want one-hot", wdone); end
        gid = -1;
        for (int b = 0; b < N; b++) if (wdone[b]) gid = b;
        got[n] = gid;
        n++;
      end
    end
    wr_en = 4'h0;
    checks++; if (n !== 5) begin errors++; $display("FAIL rr_timeout: got %0d grants want 5", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== (k % 4)) begin errors++; $display("FAIL rr_order[%0d]: got acc%0d want acc%0d", k, got[k], k % 4); end
    end
    tick;
    tick;
  endtask

  task automatic test_rd_wr_same;
    int rd_cnt, wr_cnt, rd_cyc, wr_cyc;
    bit overlap;
    rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1; overlap = 1'b0;
    rd_addr[3*AW +: AW] = 16'h3000;
    wr_addr[3*AW +: AW] = 16'h3004;
    wr_data[3*WW +: WW] = 32'hCAFE;
    rd_en[3] = 1'b1;
    wr_en[3] = 1'b1;
    tick;
    checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h3000) begin errors++; $display("FAIL same_first: got rd=%b wr=%b addr=%h want 1 0 3000", mem_rd, mem_wr, mem_addr); end
    for (int c = 0; c < 20; c++) begin
      tick;
      if (mem_wr) begin
        checks++;
        if (mem_addr !== 16'h3004 || mem_wdata !== 32'hCAFE) begin errors++; $display("FAIL same_wr_cmd: got addr=%h data=%h want 3004 0000cafe", mem_addr, mem_wdata); end
      end
      if (rvalid !== 4'b0000 && wdone !== 4'b0000) overlap = 1'b1;
      if (rvalid !== 4'b0000) begin
        rd_cnt++; rd_cyc = c; rd_en[3] = 1'b0;
        checks++;
        if (rvalid !== 4'b1000 || rdata !== line_of(16'h3000)) begin errors++; $display("FAIL same_rd: got valid=%b data=%h want 1000 %h", rvalid, rdata, line_of(16'h3000)); end
      end
      if (wdone !== 4'b0000) begin
        wr_cnt++; wr_cyc = c; wr_en[3] = 1'b0;
        checks++;
        if (wdone !== 4'b1000) begin errors++; $display("FAIL same_wr_done: got %b want 1000", wdone); end
      end
    end
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL same_rd_count: got %0d want 1", rd_cnt); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL same_wr_count: got %0d want 1", wr_cnt); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL same_overlap: got %b want 0", overlap); end
    checks++; if (!(rd_cyc >= 0 && rd_cyc < wr_cyc)) begin errors++; $display("FAIL same_order: got rd_cyc=%0d wr_cyc=%0d want read earlier", rd_cyc, wr_cyc); end
    rd_en[3] = 1'b0;
    wr_en[3] = 1'b0;
    tick;
  endtask

  task automatic test_drop_after_grant;
    int extra;
    rd_addr[0*AW +: AW] = 16'h0040;
    rd_en[0] = 1'b1;
    tick;  // T+1 (ISSUE)
    rd_en[0] = 1'b0;
    rd_addr[0*AW +: AW] = 16'hFFFF;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL drop_strobe: got rd=%b addr=%h want 1 0040", mem_rd, mem_addr); end
    tick;  // T+2
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL drop_t2: got %b want 0000", rvalid); end
    tick;  // T+3
    checks++; if (rvalid !== 4'b0001 || rdata !== line_of(16'h0040)) begin errors++; $display("FAIL drop_valid: got valid=%b data=%h want 0001 %h", rvalid, rdata, line_of(16'h0040)); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (rvalid !== 4'b0000) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_extra: got %0d extra pulses want 0", extra); end
    checks++; if (rdata !== line_of(16'h0040)) begin errors++; $display("FAIL rdata_hold: got %h want %h", rdata, line_of(16'h0040)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_read;
    bit seen1;
    rd_addr[2*AW +: AW] = 16'h2000;
    rd_en[2] = 1'b1;
    tick;  // T+1 (ISSUE)
    rd_en[2] = 1'b0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h2000) begin errors++; $display("FAIL rst_mid_strobe: got rd=%b addr=%h want 1 2000", mem_rd, mem_addr); end
    tick;  // T+2 (WAIT_RD)
    rst = 1'b1;
    tick;  // T+3
    checks++; if (rvalid !== 4'b0000 || wdone !== 4'b0000) begin errors++; $display("FAIL rst_mid_pulse: got valid=%b done=%b want 0000 0000", rvalid, wdone); end
    checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy=%b rd=%b wr=%b want 0 0 0", busy, mem_rd, mem_wr); end
    checks++; if (mem_addr !== 16'h0 || rdata !== '0) begin errors++; $display("FAIL rst_mid_data: got addr=%h rdata=%h want 0 0", mem_addr, rdata); end
    rst = 1'b0;
    tick;
    checks++; if (rvalid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_late: got valid=%b busy=%b want 0000 0", rvalid, busy); end
    rd_addr[0*AW +: AW] = 16'h0A00;
    rd_addr[1*AW +: AW] = 16'h0B00;
    rd_en = 4'b0011;
    tick;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0A00) begin errors++; $display("FAIL rst_ptr_grant: got rd=%b addr=%h want 1 0a00", mem_rd, mem_addr); end
    tick;
    tick;
    checks++; if (rvalid !== 4'b0001 || rdata !== line_of(16'h0A00)) begin errors++; $display("FAIL rst_post_valid: got valid=%b data=%h want 0001 %h", rvalid, rdata, line_of(16'h0A00)); end
    rd_en[0] = 1'b0;
    seen1 = 1'b0;
    for (int c = 0; c < 10 && !seen1; c++) begin
      tick;
      if (rvalid[1]) begin
        seen1 = 1'b1;
        rd_en[1] = 1'b0;
      end
    end
    rd_en = 4'b0000;
    checks++; if (seen1 !== 1'b1) begin errors++; $display("FAIL rst_post_acc1: got no valid for acc1 within 10 cycles, want one"); end
    tick;
    tick;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_read_lat3();
    test_round_robin();
    test_rd_wr_same();
    test_drop_after_grant();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
